// File: rtl/clock_edit_ctrl.sv
// Edit-mode controller for a clock/calendar: synchronizes and debounces three buttons, walks the edit fields,
// emits inc/dec strobes 3 cycles after a debounced press. Optional auto-repeat: define CLOCK_EDIT_AUTO_REPEAT_EN.
module clock_edit_ctrl #(
  parameter int DEB_CNT       = 500_000,
  parameter int TIMEOUT_TICKS = 10,
  parameter int REPEAT_DLY    = 25_000_000,
  parameter int REPEAT_PER    = 6_250_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       butt_change,
  input  logic       butt_increase,
  input  logic       butt_decrease,
  input  logic       sw_mode,
  input  logic       tick,
  output logic [2:0] field_sel,
  output logic       inc_pulse,
  output logic       dec_pulse,
  output logic       run_en,
  output logic       led17,
  output logic       led14,
  output logic       led10
);
  localparam int DW = $clog2(DEB_CNT + 1);
  localparam int TW = $clog2(TIMEOUT_TICKS + 1);
  localparam int RW = $clog2(((REPEAT_DLY > REPEAT_PER) ? REPEAT_DLY : REPEAT_PER) + 1);

  typedef enum logic [1:0] {IDLE, F1, F2, F3} state_t;

  // bit 0 = change, bit 1 = increase, bit 2 = decrease
  logic [2:0]    raw, s1, s2, deb, deb_d, press;
  logic [DW-1:0] dcnt [3];

  assign raw   = {butt_decrease, butt_increase, butt_change};
  assign press = deb_d & ~deb;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1    <= '1;
      s2    <= '1;
      deb   <= '1;
      deb_d <= '1;
      for (int i = 0; i < 3; i++) dcnt[i] <= '0;
    end else begin
      s1    <= raw;
      s2    <= s1;
      deb_d <= deb;
      for (int i = 0; i < 3; i++) begin
        if (s2[i] == deb[i]) begin
          dcnt[i] <= '0;
        end else if (dcnt[i] == DW'(DEB_CNT - 1)) begin
          deb[i]  <= s2[i];
          dcnt[i] <= '0;
        end else begin
          dcnt[i] <= dcnt[i] + DW'(1);
        end
      end
    end
  end

  state_t        state, nxt;
  logic          mode_q, toggle, edit, chg_evt, inc_q, dec_q;
  logic          rep_fire, rep_inc, rep_dec;
  logic [TW-1:0] to_cnt;
  logic          p1_inc, p1_dec, p2_inc, p2_dec;

  assign toggle  = sw_mode ^ mode_q;
  assign edit    = (state != IDLE);
  assign chg_evt = press[0];
  // a press only counts while the opposite button is released
  assign inc_q   = press[1] & deb[2] & ~chg_evt & ~toggle & edit;
  assign dec_q   = press[2] & deb[1] & ~chg_evt & ~toggle & edit;

`ifdef CLOCK_EDIT_AUTO_REPEAT_EN
  logic          rep_act, rep_dir, rep_first, rep_held;
  logic [RW-1:0] rep_cnt, rep_lim;

  assign rep_lim  = rep_first ? RW'(REPEAT_DLY - 1) : RW'(REPEAT_PER - 1);
  assign rep_held = rep_dir ? (!deb[2] && deb[1]) : (!deb[1] && deb[2]);
  assign rep_fire = rep_act && rep_held && edit && !toggle && !chg_evt && (rep_cnt == rep_lim);
  assign rep_inc  = rep_fire & ~rep_dir;
  assign rep_dec  = rep_fire & rep_dir;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rep_act   <= 1'b0;
      rep_dir   <= 1'b0;
      rep_first <= 1'b0;
      rep_cnt   <= '0;
    end else if (inc_q || dec_q) begin
      rep_act   <= 1'b1;
      rep_dir   <= dec_q;
      rep_first <= 1'b1;
      rep_cnt   <= '0;
    end else if (!rep_act || !rep_held || !edit || toggle) begin
      rep_act   <= 1'b0;
    end else if (rep_cnt == rep_lim) begin
      rep_first <= 1'b0;
      rep_cnt   <= '0;
    end else begin
      rep_cnt   <= rep_cnt + RW'(1);
    end
  end
`else
  logic unused_rep;
  assign unused_rep = ^{RW'(REPEAT_DLY), RW'(REPEAT_PER)};
  assign rep_fire   = 1'b0;
  assign rep_inc    = 1'b0;
  assign rep_dec    = 1'b0;
`endif

  always_comb begin
    nxt = state;
    if (toggle) begin
      nxt = IDLE;
    end else if (chg_evt) begin
      case (state)
        IDLE:    nxt = F1;
        F1:      nxt = F2;
        F2:      nxt = F3;
        default: nxt = IDLE;
      endcase
    end else if (edit && tick && !(|press) && !rep_fire && (to_cnt == TW'(TIMEOUT_TICKS - 1))) begin
      nxt = IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      mode_q    <= sw_mode;
      to_cnt    <= '0;
      field_sel <= 3'd0;
      run_en    <= 1'b1;
      led17     <= 1'b0;
      led14     <= 1'b0;
      led10     <= 1'b0;
      p1_inc    <= 1'b0;
      p1_dec    <= 1'b0;
      p2_inc    <= 1'b0;
      p2_dec    <= 1'b0;
      inc_pulse <= 1'b0;
      dec_pulse <= 1'b0;
    end else begin
      state  <= nxt;
      mode_q <= sw_mode;
      if ((|press) || rep_fire || (nxt != state)) to_cnt <= '0;
      else if (edit && tick)                      to_cnt <= to_cnt + TW'(1);
      case (nxt)
        F1:      field_sel <= sw_mode ? 3'd4 : 3'd3;
        F2:      field_sel <= sw_mode ? 3'd5 : 3'd2;
        F3:      field_sel <= sw_mode ? 3'd6 : 3'd1;
        default: field_sel <= 3'd0;
      endcase
      run_en    <= (nxt == IDLE) | sw_mode;
      led17     <= (nxt == F1);
      led14     <= (nxt == F2);
      led10     <= (nxt == F3);
      p1_inc    <= inc_q | rep_inc;
      p1_dec    <= dec_q | rep_dec;
      p2_inc    <= p1_inc & ~toggle;
      p2_dec    <= p1_dec & ~toggle;
      inc_pulse <= p2_inc & edit & ~toggle;
      dec_pulse <= p2_dec & edit & ~toggle;
    end
  end
endmodule

// File: doc/clock_edit_ctrl.md
CLOCK_EDIT_CTRL -- requirements
Module: clock_edit_ctrl

Interface
REQ-001 Parameter DEB_CNT, default 500_000, clock cycles a raw button level must be stable before it is accepted (10 ms at 50 MHz).
REQ-002 Parameter TIMEOUT_TICKS, default 10, number of tick pulses without a button event before edit mode is abandoned.
REQ-003 Parameter REPEAT_DLY, default 25_000_000, hold cycles before the first auto-repeat step.
REQ-004 Parameter REPEAT_PER, default 6_250_000, cycles between subsequent auto-repeat steps.
REQ-005 clk  in  1  single system clock; all state updates on its rising edge.
REQ-006 rst_n  in  1  synchronous, active-low reset, sampled on the rising edge of clk.
REQ-007 butt_change  in  1  raw button, asynchronous, pressed = 0.
REQ-008 butt_increase  in  1  raw button, asynchronous, pressed = 0.
REQ-009 butt_decrease  in  1  raw button, asynchronous, pressed = 0.
REQ-010 sw_mode  in  1  display mode: 0 = clock, 1 = calendar.
REQ-011 tick  in  1  one-cycle timebase pulse from the 1 s / fast delay divider.
REQ-012 field_sel  out  3  field under edit: 0 none, 1 sec, 2 min, 3 hour, 4 day, 5 month, 6 year.
REQ-013 inc_pulse  out  1  one-cycle increment strobe for the selected field.
REQ-014 dec_pulse  out  1  one-cycle decrement strobe for the selected field.
REQ-015 run_en  out  1  1 = timekeeping datapath may advance on tick.
REQ-016 led17, led14, led10  out  1 each  edit-state indicators.

Function
REQ-017 Each raw button shall pass a 2-flop synchronizer, then a debounce counter; debounced level changes only after DEB_CNT consecutive equal synchronized samples.
REQ-018 A press event shall be a debounced 1->0 transition; exactly one event per physical press, none on release.
REQ-019 FSM states IDLE, F1, F2, F3; a change event moves IDLE->F1->F2->F3->IDLE.
REQ-020 field_sel: IDLE 0; clock mode F1 3, F2 2, F3 1; calendar mode F1 4, F2 5, F3 6.
REQ-021 LEDs: IDLE all 0; F1 led17 = 1; F2 led14 = 1; F3 led10 = 1; exactly one LED high in any edit state.
REQ-022 In an edit state, an inc (dec) press event shall produce inc_pulse (dec_pulse) high for exactly one cycle, 3 cycles after the debounced edge; no pulses in IDLE.
REQ-023 Inc and dec events in the same cycle, or either button held while the other is pressed, shall produce no pulse.
REQ-024 A change event in the same cycle as an inc/dec event: the state advances and the inc/dec event is discarded.
REQ-025 run_en = 1 in IDLE; run_en = 0 in F1..F3 when sw_mode = 0; run_en = 1 in all states when sw_mode = 1.
REQ-026 Any toggle of sw_mode shall force IDLE on the next cycle and suppress pulses in that cycle.
REQ-027 Timeout counter: clears on every press event and on entry to an edit state; increments on tick while in F1..F3; on reaching TIMEOUT_TICKS, FSM returns to IDLE and the counter clears.
REQ-028 All counters shall saturate or wrap only as stated; no counter may overflow its width for the given parameter values.

Reset
REQ-029 While rst_n = 0 at a clk edge: FSM = IDLE, field_sel = 0, inc_pulse = dec_pulse = 0, run_en = 1, LEDs = 0, all counters = 0, debounced levels = 1 (released).
REQ-030 Reset asserted mid-edit or mid-debounce shall abandon that operation, with no pulse emitted afterwards for a press already in progress.

Configuration
REQ-031 Macro CLOCK_EDIT_AUTO_REPEAT_EN defined: inc or dec held in an edit state for REPEAT_DLY cycles after its press event produces an additional pulse, then one every REPEAT_PER cycles until release; each repeat pulse clears the timeout.
REQ-032 Macro not defined: no repeat logic is present; one pulse per press only.

Verification (DEB_CNT=4, TIMEOUT_TICKS=3, REPEAT_DLY=20, REPEAT_PER=8)
REQ-033 Reset, then 4 clean change presses -> field_sel 3,2,1,0 and LEDs 17,14,10,none in sequence, with run_en 0 only while field_sel != 0.
REQ-034 In F1, an inc press bouncing 3 times within 3 cycles, then held low 10 cycles -> exactly one inc_pulse, 3 cycles after the debounced edge.
REQ-035 In F2, inc and dec pressed in the same cycle -> no pulses; state stays F2.
REQ-036 In F3, 3 tick pulses with no presses -> IDLE after the third tick; an inc press afterwards -> no pulse.
REQ-037 In F1 with sw_mode = 1, toggle sw_mode to 0 -> IDLE next cycle; with the macro defined, inc held 40 cycles in F1 -> pulses at +0, +20, +28, +36 relative to the press event.
